track_mixer: RTL

TRACK_MIXER -- requirements
Module: track_mixer

---
 rtl/track_mixer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/track_mixer.sv
// Time-multiplexed tone mixer. Each frame sums routed signed tracks per output channel
// with one shared adder, then publishes all channels together.
module track_mixer #(
  parameter int NUM_TRACKS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int MIX_SHIFT   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wgEn,
  input  logic [NUM_TRACKS-1:0]                  sign,
  input  logic [NUM_TRACKS-1:0][7:0]             magnitude,
  input  logic [NUM_OUTPUTS-1:0][NUM_TRACKS-1:0] routeMask,
  input  logic                                   mute,
  output logic [NUM_OUTPUTS-1:0]                 outSign,
  output logic [NUM_OUTPUTS-1:0][7:0]            outMagnitude,
  output logic                                   outValid,
  output logic                                   overrun
);

  localparam int AW = 8 + $clog2(NUM_TRACKS) + 1;
  localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  localparam int OW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(NUM_TRACKS - 1);
  localparam logic [OW-1:0] LAST_O = OW'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACCUM, PUBLISH} state_t;

  state_t                                 state;
  logic [NUM_TRACKS-1:0]                  snap_sign;
  logic [NUM_TRACKS-1:0][7:0]             snap_mag;
  logic [NUM_OUTPUTS-1:0][NUM_TRACKS-1:0] snap_mask;
  logic                                   snap_mute;
  logic signed [AW-1:0]                   acc;
  logic [OW-1:0]                          out_idx;
  logic [TW-1:0]                          trk_idx;
  logic [NUM_OUTPUTS-1:0]                 shadow_sign;
  logic [NUM_OUTPUTS-1:0][7:0]            shadow_mag;

  logic signed [AW-1:0] term;
  logic signed [AW-1:0] sum;
  logic [AW-1:0]        abs_sum;
  logic [AW-1:0]        shifted;
  logic [7:0]           res_mag;
  logic                 res_sign;

  // The single shared adder plus the sign/shift/saturate stage for the current pair.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    term = '0;
    if (snap_mask[out_idx][trk_idx])
      term = snap_sign[trk_idx] ? -AW'(snap_mag[trk_idx]) : AW'(snap_mag[trk_idx]);
    sum      = acc + term;
    abs_sum  = sum[AW-1] ? AW'(-sum) : AW'(sum);
    shifted  = abs_sum >> MIX_SHIFT;
    res_mag  = (shifted > AW'(255)) ? 8'hFF : shifted[7:0];
    res_sign = sum[AW-1] && (res_mag != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      snap_sign    <= '0;
      snap_mag     <= '0;
      snap_mask    <= '0;
      snap_mute    <= 1'b0;
      acc          <= '0;
      out_idx      <= '0;
      trk_idx      <= '0;
      // NOTE: the shadow bank is a handful of flops, not a RAM, so it is reset with the rest.
      shadow_sign  <= '0;
      shadow_mag   <= '0;
      outSign      <= '0;
      outMagnitude <= '0;
      outValid     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      outValid <= 1'b0;
      if (wgEn && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (wgEn)
            state <= CAPTURE;
        end
        CAPTURE: begin
          snap_sign <= sign;
          snap_mag  <= magnitude;
          snap_mask <= routeMask;
          snap_mute <= mute;
          acc       <= '0;
          out_idx   <= '0;
          trk_idx   <= '0;
          state     <= ACCUM;
        end
        ACCUM: begin
          if (trk_idx == LAST_T) begin
            shadow_sign[out_idx] <= snap_mute ? 1'b0 : res_sign;
            shadow_mag[out_idx]  <= snap_mute ? 8'd0 : res_mag;
            acc     <= '0;
            trk_idx <= '0;
            if (out_idx == LAST_O)
              state <= PUBLISH;
            else
              out_idx <= out_idx + OW'(1);
          end else begin
            acc     <= sum;
            trk_idx <= trk_idx + TW'(1);
          end
        end
        PUBLISH: begin
          outSign      <= shadow_sign;
          outMagnitude <= shadow_mag;
          outValid     <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
